vector_alu_pipe: RTL
====================

VECTOR_ALU_PIPE -- requirements
Module: vector_alu_pipe

Interface
REQ-001 The block SHALL have parameter LANES, default 4, giving the lane count (even, >=2).
REQ-002 The block SHALL have parameter LANE_W, default 32, giving the lane width in bits (power of two, >=8).
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 in_op  input  3  operation code.
REQ-008 in_csub  input  1  clamp-subtract enable (SUB only).
REQ-009 in_a, in_b  input  LANES*LANE_W  packed operands; lane k = bits [k*LANE_W +: LANE_W].
REQ-010 out_valid  output  1  result beat valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_data  output  LANES*LANE_W  packed result.
REQ-013 busy  output  1  any pipeline stage holds a beat.

Function
REQ-014 Transfers SHALL occur only on in_valid&in_ready (input) and out_valid&out_ready (output).
REQ-015 Pipeline SHALL be two stages: S1 registers op/csub/operands; S2 registers computed result; latency 2 cycles from input transfer to out_valid with no stall.
REQ-016 S2 SHALL advance when !s2_valid | out_ready; S1 SHALL advance when S2 advances or !s1_valid; in_ready = !s1_valid | s1_advance (combinational, no in_valid dependence).
REQ-017 Sustained throughput SHALL be one beat/cycle while out_ready=1; no beat is dropped or duplicated under any stall pattern.
REQ-018 While out_valid&!out_ready, out_data SHALL remain stable.
REQ-019 Op 000 ADD: lane-wise a+b mod 2^LANE_W.
REQ-020 Op 001 SUB: lane-wise a-b mod 2^LANE_W; if csub=1, unsigned result clamped to 0 when b>a.
REQ-021 Op 010 MUL: lane-wise low LANE_W bits of unsigned product.
REQ-022 Op 011 SRL: a logically shifted right by b[log2(LANE_W)-1:0] per lane.
REQ-023 Op 100 PAIR: for k < LANES/2, output lanes 2k and 2k+1 both = a[k]+b[k] mod 2^LANE_W; upper input lanes ignored.
REQ-024 Op 101 AVG: lane-wise floor((a+b)/2) computed at LANE_W+1 bits (no overflow loss).
REQ-025 Op 110 MIN / 111 MAX: lane-wise unsigned minimum / maximum.
REQ-026 in_csub SHALL be ignored for all ops except SUB.
REQ-027 busy = s1_valid | s2_valid.
REQ-028 Simultaneous input and output transfer with both stages full SHALL shift pipeline by one beat without bubble.

Reset
REQ-029 On rst_n=0, s1_valid, s2_valid, out_valid, busy SHALL go 0 immediately; out_data SHALL be 0.
REQ-030 Reset mid-operation SHALL discard in-flight beats; no result from before reset appears after.
REQ-031 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-032 Package vector_alu_pkg SHALL hold the op enum (ADD,SUB,MUL,SRL,PAIR,AVG,MIN,MAX) and default LANES/LANE_W constants.
REQ-033 Per-lane arithmetic SHALL live in combinational sub-module vector_alu_lane (op, csub, a, b -> y), instantiated LANES times; PAIR routing done in vector_alu_pipe.

Verification
REQ-034 ADD, LANES=4, LANE_W=32, a lanes {FFFFFFFF,1,2,3}, b lanes {1,1,1,1}, out_ready=1 -> out_valid 2 cycles later, lanes {0,2,3,4}.
REQ-035 SUB a=5,b=7 all lanes: csub=0 -> FFFFFFFE; csub=1 -> 0.
REQ-036 PAIR a {10,20,x,x}, b {1,2,x,x} -> out lanes {11,11,22,22}; AVG a=FFFFFFFF,b=FFFFFFFF -> FFFFFFFF.
REQ-037 Stream 8 ADD beats back-to-back, out_ready pseudo-random ~50% -> all 8 results in order, none lost/duplicated, out_data stable during stalls, in_ready low only when both stages full and out_ready=0.
REQ-038 Accept 2 beats, assert rst_n=0 mid-cycle -> out_valid/busy drop asynchronously; after release in_ready=1, no stale output.

Source files
------------

// File: rtl/vector_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vector_alu_pkg
//  Purpose  : Shared op encoding and default geometry for the vector ALU pipe.
//  Revision : 1.0 - initial release
// ============================================================================
package vector_alu_pkg;

  // Operation codes carried on in_op
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_SRL  = 3'd3,
    OP_PAIR = 3'd4,
    OP_AVG  = 3'd5,
    OP_MIN  = 3'd6,
    OP_MAX  = 3'd7
  } op_e;

  // Default lane count and lane width
  localparam int c_def_lanes  = 4;
  localparam int c_def_lane_w = 32;

endpackage : vector_alu_pkg
`default_nettype wire

// File: rtl/vector_alu_lane.sv
`default_nettype none
// ============================================================================
//  Module   : vector_alu_lane
//  Purpose  : Combinational single-lane arithmetic. PAIR is computed as a
//             plain add here; the lane duplication happens in the top level.
//  Revision : 1.0 - initial release
// ============================================================================
module vector_alu_lane
  import vector_alu_pkg::*;
#(
  parameter int LANE_W = c_def_lane_w
) (
  input  logic [2:0]        op,
  input  logic              csub,
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] y
);

  localparam int c_shw = $clog2(LANE_W);

  // One extra bit keeps the carry so AVG loses nothing on overflow
  logic [LANE_W:0]   w_sum;
  logic [LANE_W-1:0] w_diff;
  logic [LANE_W-1:0] w_prod;
  logic              w_b_gt_a;

  assign w_sum    = {1'b0, a} + {1'b0, b};
  assign w_diff   = a - b;
  assign w_prod   = a * b;
  assign w_b_gt_a = (b > a);

  // Select the lane result; csub only matters for SUB
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = w_sum[LANE_W-1:0];
      OP_SUB:  y = (csub && w_b_gt_a) ? '0 : w_diff;
      OP_MUL:  y = w_prod;
      OP_SRL:  y = a >> b[c_shw-1:0];
      OP_PAIR: y = w_sum[LANE_W-1:0];
      OP_AVG:  y = w_sum[LANE_W:1];
      OP_MIN:  y = w_b_gt_a ? a : b;
      OP_MAX:  y = w_b_gt_a ? b : a;
      default: y = '0;
    endcase
  end

endmodule : vector_alu_lane
`default_nettype wire

// File: rtl/vector_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : vector_alu_pipe
//  Purpose  : Two-stage valid/ready vector ALU. S1 holds the operand beat,
//             S2 holds the computed result presented on out_data.
//  Revision : 1.0 - initial release
// ============================================================================
module vector_alu_pipe
  import vector_alu_pkg::*;
#(
  parameter int LANES  = c_def_lanes,
  parameter int LANE_W = c_def_lane_w
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_op,
  input  logic                    in_csub,
  input  logic [LANES*LANE_W-1:0] in_a,
  input  logic [LANES*LANE_W-1:0] in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic                    busy
);

  localparam int c_dw = LANES * LANE_W;

  logic            r_s1_valid;
  logic [2:0]      r_s1_op;
  logic            r_s1_csub;
  logic [c_dw-1:0] r_s1_a;
  logic [c_dw-1:0] r_s1_b;

  logic            r_s2_valid;
  logic [c_dw-1:0] r_s2_data;

  logic            w_s2_adv;
  logic            w_s1_adv;
  logic [c_dw-1:0] w_y;
  logic [c_dw-1:0] w_res;

  // S2 moves when empty or drained; S1 moves when S2 moves or S1 is empty.
  // in_ready is therefore just the S1 advance and never looks at in_valid.
  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = w_s2_adv || !r_s1_valid;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign busy      = r_s1_valid || r_s2_valid;

  // Per-lane arithmetic on the S1 operands
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    vector_alu_lane #(
      .LANE_W (LANE_W)
    ) u_lane (
      .op   (r_s1_op),
      .csub (r_s1_csub),
      .a    (r_s1_a[k*LANE_W +: LANE_W]),
      .b    (r_s1_b[k*LANE_W +: LANE_W]),
      .y    (w_y[k*LANE_W +: LANE_W])
    );
  end

  // PAIR feeds output lanes 2k and 2k+1 from lane k's sum
  for (genvar j = 0; j < LANES; j++) begin : g_route
    assign w_res[j*LANE_W +: LANE_W] = (r_s1_op == OP_PAIR)
                                     ? w_y[(j/2)*LANE_W +: LANE_W]
                                     : w_y[j*LANE_W +: LANE_W];
  end

  // S1: capture the offered beat whenever the stage advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_csub  <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op   <= in_op;
        r_s1_csub <= in_csub;
        r_s1_a    <= in_a;
        r_s1_b    <= in_b;
      end
    end
  end

  // S2: latch the result; data only changes when a new beat moves in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_res;
      end
    end
  end

endmodule : vector_alu_pipe
`default_nettype wire
